// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and state encoding
// ST_HALT exists only when IFETCH_ALIGN_CHECK_EN is defined.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_BOOT  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_DROP  = 2'd2;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam fetch_state_t ST_HALT  = 2'd3;
`endif

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - architectural PC and fetch-address registers with next-PC mux
// With IFETCH_ALIGN_CHECK_EN the target is flagged instead of masked.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redir_pc,
  input  logic        redir_req,
  input  logic        resync,
  input  logic [31:0] redirect_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] req_addr
);
  import mips_pkg::*;

  logic [31:0] pc;
  logic [31:0] target;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign target     = redirect_pc & 32'hFFFF_FFFC;
`endif

  // pc tracks where fetch should resume; req_addr is what is on the bus.
  // They differ only while a wrong-path request is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (advance) begin
        pc       <= req_addr + PC_INC;
        req_addr <= req_addr + PC_INC;
      end
      if (redir_pc) begin
        pc <= target;
      end
      if (redir_req) begin
        req_addr <= target;
      end else if (resync) begin
        req_addr <= pc;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: imem req/ack handshake, redirect flush, IF/ID register
// Optional IFETCH_ALIGN_CHECK_EN adds fetch_err and the HALT state.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     if_valid,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_pc4,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic                     fetch_err,
`endif
  output logic [OPC_MSB-OPC_LSB:0] opcode
);

  fetch_state_t state, state_d;
  logic         pend_q;
  logic         req_c;
  logic         acked;
  logic         redir_ok;
  logic         advance, redir_pc, redir_req, resync;
  logic         load, clr_valid;
  logic [31:0]  req_addr;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic redir_bad;
  assign redir_bad = redirect_valid && misaligned;
  assign redir_ok  = redirect_valid && !misaligned;
`else
  assign redir_ok  = redirect_valid;
`endif

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .redir_pc    (redir_pc),
    .redir_req   (redir_req),
    .resync      (resync),
    .redirect_pc (redirect_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
    .misaligned  (misaligned),
`endif
    .req_addr    (req_addr)
  );

  // A request raised earlier stays up until acked; stall only gates new issue.
  always_comb begin
    req_c = 1'b0;
    case (state)
      ST_FETCH: req_c = pend_q || !(if_valid && stall);
      ST_DROP:  req_c = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
      ST_HALT:  req_c = pend_q;
`endif
      default:  req_c = 1'b0;
    endcase
  end

  assign imem_req  = !rst && req_c;
  assign imem_addr = (rst || state == ST_BOOT) ? 32'h0 : req_addr;
  assign acked     = imem_req && imem_ack;
  assign opcode    = if_instr[OPC_MSB:OPC_LSB];

  always_comb begin
    state_d   = state;
    advance   = 1'b0;
    redir_pc  = 1'b0;
    redir_req = 1'b0;
    resync    = 1'b0;
    load      = 1'b0;
    clr_valid = 1'b0;
    case (state)
      ST_BOOT: begin
        state_d = ST_FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
        if (redir_bad) begin
          state_d = ST_HALT;
        end else
`endif
        if (redir_ok) begin
          redir_pc  = 1'b1;
          redir_req = 1'b1;
        end
      end
      ST_FETCH: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (redir_bad) begin
          clr_valid = 1'b1;
          state_d   = ST_HALT;
        end else
`endif
        if (redir_ok) begin
          clr_valid = 1'b1;
          redir_pc  = 1'b1;
          if (imem_req && !imem_ack) begin
            state_d = ST_DROP;
          end else begin
            redir_req = 1'b1;
          end
        end else if (acked) begin
          load    = 1'b1;
          advance = 1'b1;
        end else if (!stall) begin
          clr_valid = 1'b1;
        end
      end
      ST_DROP: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (redir_bad) begin
          state_d = ST_HALT;
        end else
`endif
        begin
          redir_pc = redir_ok;
          // The drained data is discarded; the latest redirect target wins.
          if (acked) begin
            state_d   = ST_FETCH;
            redir_req = redir_ok;
            resync    = !redir_ok;
          end
        end
      end
      default: begin
        state_d = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pend_q   <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= 32'h0;
      if_pc4   <= 32'h0;
    end else begin
      state  <= state_d;
      pend_q <= imem_req && !imem_ack;
      if (load) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= req_addr;
        if_pc4   <= req_addr + PC_INC;
      end else if (clr_valid) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (redir_bad) begin
      fetch_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (IFETCH_ALIGN_CHECK_EN optional)
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_ack, stall, redirect_valid, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc4;
  logic [5:0]  opcode;

  logic        req_b, ack_b, stall_b, rv_b, valid_b;
  logic [31:0] addr_b, rdata_b, rpc_b, instr_b, pc_b, pc4_b;
  logic [5:0]  opc_b;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_err, fe_b;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lat_cfg = 0;
  int wait_left;
  int ndeliv = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
`ifdef IFETCH_ALIGN_CHECK_EN
    .fetch_err(fetch_err),
`endif
    .opcode(opcode)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b), .stall(stall_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .if_valid(valid_b), .if_instr(instr_b), .if_pc(pc_b), .if_pc4(pc4_b),
`ifdef IFETCH_ALIGN_CHECK_EN
    .fetch_err(fe_b),
`endif
    .opcode(opc_b)
  );

  // Memory: each request waits lat_cfg cycles (random 0..3 when negative).
  always @(posedge clk) begin
    if (rst) wait_left <= 0;
    else if (!imem_req || imem_ack) wait_left <= (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    else wait_left <= wait_left - 1;
  end
  assign imem_ack   = imem_req && (wait_left == 0);
  assign imem_rdata = imem_ack ? (imem_addr ^ K) : 32'hDEAD_BEEF;
  assign ack_b      = req_b;
  assign rdata_b    = req_b ? (addr_b ^ K) : 32'hDEAD_BEEF;

  task automatic eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the delivered stream is a run of consecutive words that
  // restarts at each redirect target; memory returns addr^K.
  logic [31:0] exp_pc, cur_pc, e_ins, p_addr;
  bit          p_req, p_ack, p_valid, p_stall, p_redir;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'h0; cur_pc = 32'h0;
      p_req = 0; p_ack = 0; p_valid = 0; p_stall = 0; p_redir = 0;
    end else begin
      if (p_req && !p_ack) begin
        eq("req_held", imem_req, 1);
        eq("addr_stable", imem_addr, p_addr);
      end else if (if_valid && stall) begin
        eq("stall_no_req", imem_req, 0);
      end
      if (p_redir) begin
        eq("flush_valid", if_valid, 0);
      end else if (p_valid && p_stall) begin
        eq("hold_valid", if_valid, 1);
        eq("hold_pc", if_pc, cur_pc);
      end else if (if_valid) begin
        eq("seq_pc", if_pc, exp_pc);
        cur_pc = exp_pc;
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
      if (if_valid) begin
        e_ins = cur_pc ^ K;
        eq("instr_data", if_instr, e_ins);
        eq("opcode", opcode, e_ins[31:26]);
        eq("pc4", if_pc4, cur_pc + 32'd4);
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = if_valid; p_stall = stall; p_redir = redirect_valid;
    end
  end

  task automatic do_reset(input int lat);
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; lat_cfg = lat;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int n = 0;
    @(negedge clk);
    while (!if_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    eq(name, if_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    stall_b = 1'b0; rv_b = 1'b0; rpc_b = 32'h0; lat_cfg = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    eq("rst_req", imem_req, 0);
    eq("rst_addr", imem_addr, 0);
    eq("rst_valid", if_valid, 0);
    eq("rst_instr", if_instr, 0);
    eq("rst_pc", if_pc, 0);
    eq("rst_pc4", if_pc4, 0);
    eq("rst_opcode", opcode, 0);
    eq("rst_addr_b", addr_b, 0);
    eq("rst_pc4_b", pc4_b, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    eq("rst_err", fetch_err, 0);
`endif

    // zero-wait streaming and address wrap
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); eq("boot_req", imem_req, 0);
    @(negedge clk); eq("first_req", imem_req, 1); eq("first_addr", imem_addr, 0);
    @(negedge clk);
    eq("first_valid", if_valid, 1); eq("first_pc", if_pc, 0);
    eq("first_instr", if_instr, 32'hA5A5_0000); eq("first_opcode", opcode, 6'h29);
    eq("wrap_pc0", pc_b, 32'hFFFF_FFF8); eq("wrap_instr0", instr_b, 32'h5A5A_FFF8);
    @(negedge clk);
    eq("second_pc", if_pc, 4); eq("wrap_pc1", pc_b, 32'hFFFF_FFFC); eq("wrap_pc4", pc4_b, 0);
    @(negedge clk);
    eq("third_pc", if_pc, 8); eq("wrap_pc2", pc_b, 0); eq("wrap_valid2", valid_b, 1);

    // three-cycle ack latency
    @(posedge clk); #1 lat_cfg = 3;
    @(negedge clk); eq("lat_pre_ack", imem_ack, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      eq("lat_req", imem_req, 1);
      eq("lat_addr", imem_addr, 32'd20);
      eq("lat_ack", imem_ack, 32'(k == 4));
      if (k > 1) eq("lat_gap", if_valid, 0);
    end
    @(negedge clk); eq("lat_valid", if_valid, 1); eq("lat_pc", if_pc, 32'd20);
    @(negedge clk); eq("lat_pulse_end", if_valid, 0);

    // stall for 5 cycles with a valid instruction
    do_reset(0);
    wait_valid(10, "stall_start");
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eq("stall_valid", if_valid, 1);
      eq("stall_pc", if_pc, 32'd4);
      eq("stall_instr", if_instr, 32'd4 ^ K);
      eq("stall_req", imem_req, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk); eq("resume_req", imem_req, 1); eq("resume_addr", imem_addr, 32'd8);
    @(negedge clk); eq("resume_pc", if_pc, 32'd8);

    // redirect with a pending request drains into DROP
    do_reset(2);
    @(posedge clk); #1;
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk); eq("drop_pending_req", imem_req, 1); eq("drop_pending_ack", imem_ack, 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk); eq("drop_req", imem_req, 1); eq("drop_addr", imem_addr, 0); eq("drop_ack", imem_ack, 1);
    @(negedge clk); eq("drop_valid", if_valid, 0); eq("drop_newaddr", imem_addr, 32'h100);
    wait_valid(12, "drop_refetch");
    eq("drop_pc", if_pc, 32'h100);

    // redirect in the same cycle as an ack: no DROP
    do_reset(0);
    wait_valid(10, "sc_start");
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk); eq("sc_ack", imem_ack, 1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk); eq("sc_req", imem_req, 1); eq("sc_addr", imem_addr, 32'h200); eq("sc_valid", if_valid, 0);
    @(negedge clk); eq("sc_pc", if_pc, 32'h200);

    // misaligned redirect
    do_reset(0);
    wait_valid(10, "mis_start");
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(posedge clk); #1 redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    @(negedge clk); eq("mis_err", fetch_err, 1); eq("mis_valid", if_valid, 0);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eq("halt_req", imem_req, 0);
      eq("halt_err", fetch_err, 1);
    end
    do_reset(0);
    @(negedge clk); eq("err_cleared", fetch_err, 0);
    wait_valid(10, "halt_exit");
`else
    wait_valid(10, "mis_refetch");
    eq("mis_pc", if_pc, 32'h100);
`endif

    // randomized traffic against the model
    do_reset(-1);
    wait_valid(20, "rand_start");
    n0 = ndeliv;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef IFETCH_ALIGN_CHECK_EN
      redirect_pc = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc = $urandom;
`endif
    end
    @(posedge clk); #1 stall = 1'b0; redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    eq("rand_progress", 32'(ndeliv - n0 > 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
